// File: rtl/arith_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit_arbiter
//  Description : Two-requester round-robin front end for a shared, registered
//                arithmetic unit. Grants one operation at a time, issues it
//                for a single cycle, captures the result and holds it until
//                the consumer accepts it.
//  Options     : DIV_ZERO_GUARD_EN - when defined, divide-by-zero requests
//                are answered locally (all-ones result, RSP_ERR=1) without
//                ever enabling the arithmetic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              RST,

  input  logic              REQ0_VALID,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_B,
  input  logic [1:0]        REQ0_FUN,
  output logic              REQ0_ACK,

  input  logic              REQ1_VALID,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_B,
  input  logic [1:0]        REQ1_FUN,
  output logic              REQ1_ACK,

  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_CARRY,
  output logic              RSP_ERR,

  output logic              AU_EN,
  output logic [DATA_W-1:0] AU_A,
  output logic [DATA_W-1:0] AU_B,
  output logic [3:0]        AU_FUN,
  input  logic [DATA_W-1:0] AU_OUT,
  input  logic              AU_CARRY,

  output logic              BUSY
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        fun_q, fun_d;
  logic              id_q, id_d;
  // Identity of the requester granted most recently (1 = requester 1).
  logic              last_q, last_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_carry_q, rsp_carry_d;
`ifdef DIV_ZERO_GUARD_EN
  logic              rsp_err_q, rsp_err_d;
  logic              w_div0;
`endif

  logic              w_grant0;
  logic              w_grant1;
  logic              w_any;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [1:0]        w_sel_fun;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    w_grant1  = REQ1_VALID && (!REQ0_VALID || !last_q);
    w_grant0  = REQ0_VALID && !w_grant1;
    w_any     = w_grant0 || w_grant1;
    w_sel_a   = w_grant1 ? REQ1_A   : REQ0_A;
    w_sel_b   = w_grant1 ? REQ1_B   : REQ0_B;
    w_sel_fun = w_grant1 ? REQ1_FUN : REQ0_FUN;
`ifdef DIV_ZERO_GUARD_EN
    w_div0    = (w_sel_fun == 2'b11) && (w_sel_b == '0);
`endif
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= 2'b00;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
`ifdef DIV_ZERO_GUARD_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
`ifdef DIV_ZERO_GUARD_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next-state sequencing: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
`ifdef DIV_ZERO_GUARD_EN
          state_d = w_div0 ? ST_RESP : ST_ISSUE;
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        if (RSP_READY) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Latch the granted request and capture the unit's registered result.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    id_d        = id_q;
    last_d      = last_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
`ifdef DIV_ZERO_GUARD_EN
    rsp_err_d   = rsp_err_q;
`endif
    if ((state_q == ST_IDLE) && w_any) begin
      a_d    = w_sel_a;
      b_d    = w_sel_b;
      fun_d  = w_sel_fun;
      id_d   = w_grant1;
      last_d = w_grant1;
`ifdef DIV_ZERO_GUARD_EN
      // A guarded divide-by-zero answers directly from here.
      rsp_err_d = w_div0;
      if (w_div0) begin
        rsp_data_d  = '1;
        rsp_carry_d = 1'b0;
      end
`endif
    end
    if (state_q == ST_CAPTURE) begin
      rsp_data_d  = AU_OUT;
      rsp_carry_d = AU_CARRY;
    end
  end

  // Outputs; operands to the unit are forced to zero outside ISSUE.
  always_comb begin
    REQ0_ACK  = 1'b0;
    REQ1_ACK  = 1'b0;
    AU_EN     = 1'b0;
    AU_A      = '0;
    AU_B      = '0;
    AU_FUN    = 4'b0000;
    RSP_VALID = 1'b0;
    BUSY      = (state_q != ST_IDLE);
    RSP_ID    = id_q;
    RSP_DATA  = rsp_data_q;
    RSP_CARRY = rsp_carry_q;
`ifdef DIV_ZERO_GUARD_EN
    RSP_ERR   = rsp_err_q;
`else
    RSP_ERR   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Gate with reset so no grant pulse appears while reset is held.
        REQ0_ACK = RST && w_grant0;
        REQ1_ACK = RST && w_grant1;
      end
      ST_ISSUE: begin
        AU_EN  = 1'b1;
        AU_A   = a_q;
        AU_B   = b_q;
        AU_FUN = {2'b00, fun_q};
      end
      ST_RESP: RSP_VALID = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
